// File: rtl/serial_pkg.sv
// serial_pkg: constants shared by the serial link transmitter and receiver.
//   - FSM state encodings (IDLE/START/DATA/STOP)
//   - line levels for idle, start bit and stop bit
//   - cnt_width(): counter width helper, never narrower than 1 bit
package serial_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width needed to hold 0..n-1; a 1-count still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// bit_timer: divides the clock into serial bit periods.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   clear   in  hold the count at 0 (used while the line is idle)
//   tick    out high during the last cycle (count == BIT_CYCLES-1) of a bit
module bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    // Wrapping on tick restarts the count at every bit boundary, so each
    // state change in the transmitter starts a fresh bit period.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-in/serial-out transmitter.
// A word accepted over valid/ready is sent LSB first between a start bit (0)
// and a stop bit (1); every bit is held for BIT_CYCLES clocks.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   data       in   word to send, sampled only on the accept edge
//   valid      in   data is valid
//   ready      out  can accept a word (IDLE only)
//   serial_out out  serial line, idles high
//   busy       out  frame in progress
//   done       out  one-cycle pulse as the frame completes
//   dbg_state  out  current FSM state
// Handshake: a word transfers on a rising edge where valid && ready. ready
// does not depend on valid; valid while ready is low is simply ignored.
module piso_serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             line_q,    line_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] shifted;
    logic             tick;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (ready),
        .tick   (tick)
    );

    assign shifted = shift_q >> 1;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        line_d    = line_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                line_d = LINE_IDLE;
                if (valid) begin
                    // load
                    state_d   = START;
                    shift_d   = data;
                    bit_cnt_d = '0;
                    line_d    = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    line_d  = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        line_d    = STOP_BIT;
                    end else begin
                        // shift: next bit comes out of position 0
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        line_d    = shifted[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    line_d  = LINE_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            line_q    <= LINE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
            done_q    <= done_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign busy       = !ready;
    assign serial_out = line_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

    localparam int W   = 8;
    localparam int BC0 = 4;
    localparam int BC1 = 1;

    // clock / reset
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [W-1:0] data0 = '0, data1 = '0;
    logic         valid0 = 1'b0, valid1 = 1'b0;
    logic         ready0, so0, busy0, done0;
    logic         ready1, so1, busy1, done1;
    logic [1:0]   st0, st1;

    piso_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC0)) dut0 (
        .clock(clock), .reset_n(reset_n), .data(data0), .valid(valid0),
        .ready(ready0), .serial_out(so0), .busy(busy0), .done(done0),
        .dbg_state(st0)
    );

    piso_serial_tx #(.WIDTH(W), .BIT_CYCLES(BC1)) dut1 (
        .clock(clock), .reset_n(reset_n), .data(data1), .valid(valid1),
        .ready(ready1), .serial_out(so1), .busy(busy1), .done(done1),
        .dbg_state(st1)
    );

    logic         vld_a[2], so_a[2], busy_a[2], ready_a[2], done_a[2];
    logic [W-1:0] din_a[2];
    assign vld_a[0] = valid0;  assign vld_a[1] = valid1;
    assign din_a[0] = data0;   assign din_a[1] = data1;
    assign so_a[0]  = so0;     assign so_a[1]  = so1;
    assign busy_a[0]  = busy0;  assign busy_a[1]  = busy1;
    assign ready_a[0] = ready0; assign ready_a[1] = ready1;
    assign done_a[0]  = done0;  assign done_a[1]  = done1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: words expected from the receiver model, per instance
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // reference model: position within the frame, counted in edges since accept
    int           bc[2] = '{BC0, BC1};
    bit           m_active[2] = '{1'b0, 1'b0};
    int           m_j[2] = '{0, 0};
    logic [W-1:0] m_word[2];
    bit           m_done[2] = '{1'b0, 1'b0};

    function automatic logic exp_line(input int i, input int j);
        int b;
        b = j / bc[i];
        if (b == 0) return 1'b0;
        if (b <= W) return m_word[i][b-1];
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                if (m_active[i]) begin
                    // frame cut by reset is dropped
                    if (i == 0) void'(exp_q0.pop_back());
                    else        void'(exp_q1.pop_back());
                end
                m_active[i] = 1'b0;
                m_done[i]   = 1'b0;
                m_j[i]      = 0;
            end else begin
                m_done[i] = 1'b0;
                if (m_active[i]) begin
                    m_j[i]++;
                    if (m_j[i] == (W + 2) * bc[i]) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = 1'b1;
                    end
                end else if (vld_a[i] === 1'b1) begin
                    m_active[i] = 1'b1;
                    m_j[i]      = 0;
                    m_word[i]   = din_a[i];
                    if (i == 0) exp_q0.push_back(din_a[i]);
                    else        exp_q1.push_back(din_a[i]);
                end
            end
        end
    end

    // monitor: cycle checks against the model plus a mid-bit sampling receiver
    bit           rx_on[2] = '{1'b0, 1'b0};
    int           rx_j[2] = '{0, 0};
    logic [W-1:0] rx_word[2];

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic exp_so;
            int   pos;
            int   b;
            exp_so = m_active[i] ? exp_line(i, m_j[i]) : 1'b1;
            check($sformatf("serial_out[%0d]", i), so_a[i], exp_so);
            check($sformatf("busy[%0d]", i), busy_a[i], m_active[i]);
            check($sformatf("ready[%0d]", i), ready_a[i], !m_active[i]);
            check($sformatf("done[%0d]", i), done_a[i], m_done[i]);
            if (!reset_n) begin
                rx_on[i] = 1'b0;
            end else begin
                if (!rx_on[i] && so_a[i] === 1'b0) begin
                    rx_on[i] = 1'b1;
                    rx_j[i]  = 0;
                end
                if (rx_on[i]) begin
                    pos = rx_j[i] - bc[i] / 2;
                    if (pos >= 0 && (pos % bc[i]) == 0) begin
                        b = pos / bc[i];
                        if (b == 0) begin
                            check($sformatf("rx_start[%0d]", i), so_a[i], 1'b0);
                        end else if (b <= W) begin
                            rx_word[i][b-1] = so_a[i];
                        end else begin
                            check($sformatf("rx_stop[%0d]", i), so_a[i], 1'b1);
                            if (i == 0) begin
                                if (exp_q0.size() == 0) check("rx_unexpected[0]", 1, 0);
                                else check("rx_word[0]", rx_word[i], exp_q0.pop_front());
                            end else begin
                                if (exp_q1.size() == 0) check("rx_unexpected[1]", 1, 0);
                                else check("rx_word[1]", rx_word[i], exp_q1.pop_front());
                            end
                            rx_on[i] = 1'b0;
                        end
                    end
                    rx_j[i]++;
                end
            end
        end
    end

    // driver tasks
    task automatic send0(input logic [W-1:0] w);
        @(negedge clock);
        valid0 = 1'b1;
        data0  = w;
        @(negedge clock);
        valid0 = 1'b0;
        data0  = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // reset idle
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(20);

        // single frame A5, with FF offered while busy from k+10 for 5 cycles
        send0(8'hA5);
        idle(9);
        valid0 = 1'b1;
        data0  = 8'hFF;
        idle(5);
        valid0 = 1'b0;
        idle(35);

        // back-to-back with valid held: 01 then 80
        valid0 = 1'b1;
        data0  = 8'h01;
        idle(2);
        data0  = 8'h80;
        idle(44);
        valid0 = 1'b0;
        idle(45);

        // reset inside DATA, then a clean frame
        send0(8'h5A);
        idle(16);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_serial_out", so0, 1'b1);
        check("async_rst_busy", busy0, 1'b0);
        check("async_rst_done", done0, 1'b0);
        check("async_rst_ready", ready0, 1'b1);
        idle(3);
        reset_n = 1'b1;
        send0(8'h3C);
        idle(45);

        // one bit per cycle
        @(negedge clock);
        valid1 = 1'b1;
        data1  = 8'h55;
        @(negedge clock);
        valid1 = 1'b0;
        idle(15);

        // random traffic on both transmitters
        repeat (1200) begin
            @(negedge clock);
            valid0 = ($urandom_range(0, 3) == 0);
            data0  = W'($urandom);
            valid1 = ($urandom_range(0, 2) == 0);
            data1  = W'($urandom);
        end
        valid0 = 1'b0;
        valid1 = 1'b0;
        idle(60);

        check("pending_words[0]", exp_q0.size(), 0);
        check("pending_words[1]", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
